// File: rtl/dbg_defs.sv
// rtl/dbg_defs.sv - shared command bytes, state encoding and sizing constants for the pipeline debug unit
package dbg_defs;

   localparam logic [7:0] CMD_STEP  = 8'h53;
   localparam logic [7:0] CMD_RUN   = 8'h43;
   localparam logic [7:0] CMD_DUMP  = 8'h44;
   localparam logic [7:0] CMD_ABORT = 8'h50;

   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STEP,
      ST_RUN,
      ST_LATCH,
      ST_SEND
   } dbg_state_e;

endpackage

// File: rtl/dbg_tx_serializer.sv
// rtl/dbg_tx_serializer.sv - shadow snapshot register and MSB-first valid/ready byte streamer
module dbg_tx_serializer
   import dbg_defs::*;
#(
   parameter int NUM_WORDS = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          load_i,
   input  logic [32*(NUM_WORDS+1)-1:0]   data_i,
   input  logic                          tx_ready_i,
   output logic [7:0]                    tx_data_o,
   output logic                          tx_valid_o,
   output logic                          done_o
);

   localparam int NBYTES = BYTES_PER_WORD * (NUM_WORDS + 1);
   localparam int IW = $clog2(NBYTES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   logic [7:0]    shadow_q [NBYTES];
   logic [IW-1:0] idx_q;
   logic          valid_q;
   logic          xfer;

   assign xfer       = valid_q && tx_ready_i;
   assign done_o     = xfer && (idx_q == LAST_IDX);
   assign tx_valid_o = valid_q;
   // Shadow is stored in send order, so the byte mux is a plain index.
   assign tx_data_o  = shadow_q[idx_q];

   // Capture the bus into send order: word by word, most significant byte first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NBYTES; i++) shadow_q[i] <= '0;
      end else if (load_i) begin
         for (int w = 0; w <= NUM_WORDS; w++) begin
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
               shadow_q[w*BYTES_PER_WORD + b] <= data_i[w*32 + (BYTES_PER_WORD-1-b)*8 +: 8];
            end
         end
      end
   end

   // Handshake: hold byte while stalled, advance one byte per accepted transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         idx_q   <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         idx_q   <= '0;
      end else if (xfer) begin
         if (idx_q == LAST_IDX) valid_q <= 1'b0;
         else                   idx_q   <= idx_q + IW'(1);
      end
   end

endmodule

// File: rtl/pipeline_debug_unit.sv
// rtl/pipeline_debug_unit.sv - byte-command debug FSM with pipe_en gating and cycle counter; DBG_ABORT_EN adds 'P' abort in RUN
module pipeline_debug_unit
   import dbg_defs::*;
#(
   parameter int NUM_WORDS = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [7:0]                rx_data,
   input  logic                      rx_valid,
   output logic [7:0]                tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   input  logic [32*NUM_WORDS-1:0]   snap_data,
   input  logic                      halted,
   output logic                      pipe_en,
   output logic [31:0]               cycle_count,
   output logic                      busy
);

   dbg_state_e  state_q;
   logic [31:0] count_q;
   logic [31:0] count_d;
   logic        abort_hit;
   logic        tx_done;

`ifdef DBG_ABORT_EN
   assign abort_hit = (state_q == ST_RUN) && rx_valid && (rx_data == CMD_ABORT);
`else
   assign abort_hit = 1'b0;
`endif

   // An abort byte suppresses the enable in the very cycle it arrives.
   assign pipe_en     = ((state_q == ST_STEP) || ((state_q == ST_RUN) && !abort_hit)) && !halted;
   assign count_d     = pipe_en ? count_q + 32'd1 : count_q;
   assign cycle_count = count_q;
   assign busy        = (state_q != ST_IDLE);

   // Count enabled pipeline cycles, wrapping naturally at 2^32.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end

   // Command FSM: decode in IDLE, run the pipeline, latch, then stream the dump.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rx_valid) begin
                  case (rx_data)
                     CMD_STEP: state_q <= ST_STEP;
                     CMD_RUN:  state_q <= ST_RUN;
                     CMD_DUMP: state_q <= ST_LATCH;
                     default:  state_q <= ST_IDLE;
                  endcase
               end
            end
            ST_STEP:  state_q <= ST_LATCH;
            ST_RUN:   if (halted || abort_hit) state_q <= ST_LATCH;
            ST_LATCH: state_q <= ST_SEND;
            ST_SEND:  if (tx_done) state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   dbg_tx_serializer #(
      .NUM_WORDS (NUM_WORDS)
   ) u_tx (
      .clk        (clk),
      .rst_n      (reset),
      .load_i     (state_q == ST_LATCH),
      .data_i     ({snap_data, count_q}),
      .tx_ready_i (tx_ready),
      .tx_data_o  (tx_data),
      .tx_valid_o (tx_valid),
      .done_o     (tx_done)
   );

endmodule

// File: tb/tb_pipeline_debug_unit.sv
// tb/tb_pipeline_debug_unit.sv - randomized self-checking bench for pipeline_debug_unit
module tb_pipeline_debug_unit;

   localparam int NW = 8;
   localparam int NB = 4 * (NW + 1);
   localparam logic [7:0] B_STEP  = 8'h53;
   localparam logic [7:0] B_RUN   = 8'h43;
   localparam logic [7:0] B_DUMP  = 8'h44;
   localparam logic [7:0] B_ABORT = 8'h50;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_valid = 1'b0;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready = 1'b1;
   logic [32*NW-1:0]  snap_data = '0;
   logic              halted = 1'b0;
   logic              pipe_en;
   logic [31:0]       cycle_count;
   logic              busy;

   int          checks = 0;
   int          errors = 0;
   int          ready_mode = 0;
   logic [31:0] model_count = 32'd0;
   logic [31:0] exp_w [NW+1];
   logic [7:0]  got_q [$];
   int          pe_cnt = 0;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h00;

   always #5 clk = ~clk;

   pipeline_debug_unit #(.NUM_WORDS(NW)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .snap_data   (snap_data),
      .halted      (halted),
      .pipe_en     (pipe_en),
      .cycle_count (cycle_count),
      .busy        (busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Receiver back-pressure pattern.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = ~tx_ready;
         default: tx_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Mid-cycle monitor: collects accepted bytes, counts enabled cycles, checks stall stability.
   always @(negedge clk) begin
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", tx_valid, 1);
            chk("stall_data", tx_data, prev_data);
         end
         if (pipe_en) pe_cnt++;
         if (tx_valid && tx_ready) got_q.push_back(tx_data);
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic rand_snap();
      for (int i = 0; i < NW; i++) snap_data[32*i +: 32] = $urandom;
   endtask

   task automatic snap_expect();
      exp_w[0] = model_count;
      for (int i = 0; i < NW; i++) exp_w[i+1] = snap_data[32*i +: 32];
   endtask

   // Wait for a full dump after base, scrambling snap_data once streaming starts.
   task automatic wait_dump(input int base, input string tag);
      int   n = 0;
      logic scrambled = 1'b0;
      logic dropped = 1'b0;
      while (got_q.size() < base + NB && n < 3000) begin
         if (!busy) dropped = 1'b1;
         if (tx_valid && !scrambled) begin
            rand_snap();
            scrambled = 1'b1;
         end
         tick();
         n++;
      end
      chk({tag, "_done"}, (got_q.size() >= base + NB), 1);
      chk({tag, "_busy_hold"}, dropped, 0);
      if (got_q.size() >= base + NB) begin
         for (int w = 0; w <= NW; w++)
            chk($sformatf("%s_w%0d", tag, w),
                {got_q[base+4*w], got_q[base+4*w+1], got_q[base+4*w+2], got_q[base+4*w+3]}, exp_w[w]);
      end
      tick();
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_nbytes"}, got_q.size(), base + NB);
      chk({tag, "_count"}, cycle_count, model_count);
   endtask

   // 'S' or 'D' with latency checks.
   task automatic do_short(input logic [7:0] cmd, input string tag);
      int base = got_q.size();
      int pb   = pe_cnt;
      int lat  = (cmd == B_DUMP) ? 1 : 2;
      int pe_exp = (cmd == B_STEP && !halted) ? 1 : 0;
      model_count += 32'(pe_exp);
      snap_expect();
      send_byte(cmd);
      if (cmd == B_STEP) chk({tag, "_pe"}, pipe_en, 32'(pe_exp));
      repeat (lat - 1) tick();
      chk({tag, "_v0"}, tx_valid, 0);
      tick();
      chk({tag, "_v1"}, tx_valid, 1);
      wait_dump(base, tag);
      chk({tag, "_pecnt"}, pe_cnt - pb, pe_exp);
   endtask

   // 'C' with halted raised k cycles into RUN.
   task automatic do_run(input int k, input string tag);
      int base = got_q.size();
      int pb   = pe_cnt;
      send_byte(B_RUN);
      repeat (k) tick();
      halted = 1'b1;
      model_count += 32'(k);
      snap_expect();
      wait_dump(base, tag);
      halted = 1'b0;
      chk({tag, "_pecnt"}, pe_cnt - pb, k);
   endtask

   initial begin
      int base;
      int pb;
      int n;
      logic [7:0] junk;

      rand_snap();
      tick();
      tick();
      chk("rst_valid", tx_valid, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_pe", pipe_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", cycle_count, 0);
      reset = 1'b1;
      tick();

      // Single step from reset: count 1, 36 bytes starting 00 00 00 01.
      ready_mode = 0;
      rand_snap();
      do_short(B_STEP, "step");

      // Run halted after 10 enabled cycles.
      rand_snap();
      do_run(10, "run10");

      // Dump with DEADBEEF in word 0 under toggling ready.
      ready_mode = 1;
      rand_snap();
      snap_data[31:0] = 32'hDEADBEEF;
      base = got_q.size();
      do_short(B_DUMP, "dead");
      chk("dead_b5", got_q[base+4], 8'hDE);
      chk("dead_b8", got_q[base+7], 8'hEF);

      // 'S' during SEND is dropped.
      ready_mode = 2;
      rand_snap();
      base = got_q.size();
      pb = pe_cnt;
      snap_expect();
      send_byte(B_DUMP);
      n = 0;
      while (!tx_valid && n < 20) begin tick(); n++; end
      send_byte(B_STEP);
      wait_dump(base, "s_in_send");
      repeat (20) tick();
      chk("s_in_send_extra", got_q.size(), base + NB);
      chk("s_in_send_pe", pe_cnt - pb, 0);

      // Already halted: no enabled cycle, dump still follows.
      ready_mode = 0;
      halted = 1'b1;
      do_short(B_STEP, "step_halted");
      halted = 1'b1;
      do_run(0, "run_halted");

      // Unknown byte in IDLE is ignored.
      do junk = 8'($urandom); while (junk == B_STEP || junk == B_RUN || junk == B_DUMP);
      base = got_q.size();
      send_byte(junk);
      repeat (10) tick();
      chk("junk_busy", busy, 0);
      chk("junk_bytes", got_q.size(), base);

      // Abort byte in RUN.
      rand_snap();
      base = got_q.size();
      pb = pe_cnt;
      send_byte(B_RUN);
`ifdef DBG_ABORT_EN
      repeat (5) tick();
      send_byte(B_ABORT);
      model_count += 32'd5;
      snap_expect();
      wait_dump(base, "abort");
      chk("abort_pe", pe_cnt - pb, 5);
`else
      repeat (3) tick();
      send_byte(B_ABORT);
      repeat (5) tick();
      halted = 1'b1;
      model_count += 32'd9;
      snap_expect();
      wait_dump(base, "noabort");
      halted = 1'b0;
      chk("noabort_pe", pe_cnt - pb, 9);
`endif

      // Reset after byte 3 of a dump.
      ready_mode = 0;
      snap_expect();
      base = got_q.size();
      send_byte(B_DUMP);
      n = 0;
      while (got_q.size() < base + 3 && n < 50) begin tick(); n++; end
      reset = 1'b0;
      #1;
      chk("mrst_valid", tx_valid, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_count", cycle_count, 0);
      model_count = 32'd0;
      base = got_q.size();
      tick();
      tick();
      reset = 1'b1;
      repeat (10) tick();
      chk("mrst_nobytes", got_q.size(), base);
      rand_snap();
      do_short(B_DUMP, "after_rst");

      // Randomized mix.
      for (int it = 0; it < 12; it++) begin
         ready_mode = $urandom_range(0, 2);
         rand_snap();
         case ($urandom_range(0, 3))
            0: begin
               halted = ($urandom_range(0, 3) == 0);
               do_short(B_STEP, $sformatf("r%0d_step", it));
               halted = 1'b0;
            end
            1: do_run($urandom_range(1, 25), $sformatf("r%0d_run", it));
            2: do_short(B_DUMP, $sformatf("r%0d_dump", it));
            default: begin
               do junk = 8'($urandom); while (junk == B_STEP || junk == B_RUN || junk == B_DUMP);
               base = got_q.size();
               send_byte(junk);
               repeat (5) tick();
               chk($sformatf("r%0d_junk", it), got_q.size(), base);
            end
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
